// File: rtl/data_memory_responder_if.sv
// Load/store request and response channel between the core and its data memory.
interface data_memory_responder_if #(
    parameter int ADDR_WIDTH = 18
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_read;
    logic                  req_write;
    logic                  req_byte;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_rdata;
    logic                  resp_error;

    modport master (
        output req_valid, req_read, req_write, req_byte, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_read, req_write, req_byte, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface

// File: rtl/data_memory_responder.sv
// Memory-side responder: one outstanding load/store, fixed LATENCY wait cycles,
// little-endian word/byte access, illegal requests answered with resp_error.
module data_memory_responder #(
    parameter int ADDR_WIDTH  = 18,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input logic                    clock,
    input logic                    reset_n,
    data_memory_responder_if.slave bus
);
    localparam int                  IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  error_q, error_d;
    logic                  read_q, write_q, byte_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           mem [DEPTH_WORDS];

    logic                  commit;
    logic                  cur_read, cur_write, cur_byte, cur_error;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [31:0]           cur_wdata;
    logic [IDX_W-1:0]      word_idx;
    logic [1:0]            lane;
    logic [31:0]           word_rd;
    logic [7:0]            byte_rd;

    // With LATENCY=0 the commit coincides with the accept edge, so the live request is used.
    assign cur_read  = (state_q == S_IDLE) ? bus.req_read  : read_q;
    assign cur_write = (state_q == S_IDLE) ? bus.req_write : write_q;
    assign cur_byte  = (state_q == S_IDLE) ? bus.req_byte  : byte_q;
    assign cur_addr  = (state_q == S_IDLE) ? bus.req_addr  : addr_q;
    assign cur_wdata = (state_q == S_IDLE) ? bus.req_wdata : wdata_q;

    assign cur_error = (cur_read == cur_write)
                     || (!cur_byte && (cur_addr[1:0] != 2'b00))
                     || ({1'b0, cur_addr} >= ADDR_LIMIT);
    assign word_idx  = cur_addr[IDX_W+1:2];
    assign lane      = cur_addr[1:0];
    assign word_rd   = mem[word_idx];
    assign byte_rd   = word_rd[{lane, 3'b000} +: 8];

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_error = error_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        error_d = error_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (LATENCY == 0) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    state_d = S_IDLE;
                    rdata_d = 32'h0;
                    error_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (commit) begin
            error_d = cur_error;
            if (cur_error || cur_write) begin
                rdata_d = 32'h0;
            end else if (cur_byte) begin
                rdata_d = {{24{byte_rd[7]}}, byte_rd};
            end else begin
                rdata_d = word_rd;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    // NOTE: storage and captured request fields are deliberately not reset; only the commit is gated.
    always_ff @(posedge clock) begin
        if (state_q == S_IDLE && bus.req_valid) begin
            read_q  <= bus.req_read;
            write_q <= bus.req_write;
            byte_q  <= bus.req_byte;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
        if (reset_n && commit && cur_write && !cur_error) begin
            if (cur_byte) begin
                mem[word_idx][{lane, 3'b000} +: 8] <= cur_wdata[7:0];
            end else begin
                mem[word_idx] <= cur_wdata;
            end
        end
    end
endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench: three responders (LATENCY 2, 4, 0) share one driven request
// channel, steered by sel; expected responses come from a bench-side memory model.
module tb_data_memory_responder;
    localparam int DEPTH = 1024;

    typedef struct {
        logic [31:0] rdata;
        logic        error;
        int          lat;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    int          sel = 0;
    logic        req_valid = 1'b0, req_read = 1'b0, req_write = 1'b0, req_byte = 1'b0;
    logic [17:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_ready = 1'b0;
    logic        req_ready, resp_valid, resp_error;
    logic [31:0] resp_rdata;

    int          vectors = 0;
    int          miscompares = 0;
    exp_t        sb[$];
    logic [31:0] model [int];

    always #5 clock = ~clock;

    data_memory_responder_if #(.ADDR_WIDTH(18)) bus0 ();
    data_memory_responder_if #(.ADDR_WIDTH(18)) bus1 ();
    data_memory_responder_if #(.ADDR_WIDTH(18)) bus2 ();

    assign bus0.req_valid = req_valid && (sel == 0);
    assign bus1.req_valid = req_valid && (sel == 1);
    assign bus2.req_valid = req_valid && (sel == 2);
    assign bus0.req_read  = req_read;   assign bus1.req_read  = req_read;   assign bus2.req_read  = req_read;
    assign bus0.req_write = req_write;  assign bus1.req_write = req_write;  assign bus2.req_write = req_write;
    assign bus0.req_byte  = req_byte;   assign bus1.req_byte  = req_byte;   assign bus2.req_byte  = req_byte;
    assign bus0.req_addr  = req_addr;   assign bus1.req_addr  = req_addr;   assign bus2.req_addr  = req_addr;
    assign bus0.req_wdata = req_wdata;  assign bus1.req_wdata = req_wdata;  assign bus2.req_wdata = req_wdata;
    assign bus0.resp_ready = resp_ready; assign bus1.resp_ready = resp_ready; assign bus2.resp_ready = resp_ready;

    assign req_ready  = (sel == 0) ? bus0.req_ready  : (sel == 1) ? bus1.req_ready  : bus2.req_ready;
    assign resp_valid = (sel == 0) ? bus0.resp_valid : (sel == 1) ? bus1.resp_valid : bus2.resp_valid;
    assign resp_rdata = (sel == 0) ? bus0.resp_rdata : (sel == 1) ? bus1.resp_rdata : bus2.resp_rdata;
    assign resp_error = (sel == 0) ? bus0.resp_error : (sel == 1) ? bus1.resp_error : bus2.resp_error;

    data_memory_responder #(.ADDR_WIDTH(18), .DEPTH_WORDS(DEPTH), .LATENCY(2)) u_lat2 (
        .clock(clock), .reset_n(reset_n), .bus(bus0));
    data_memory_responder #(.ADDR_WIDTH(18), .DEPTH_WORDS(DEPTH), .LATENCY(4)) u_lat4 (
        .clock(clock), .reset_n(reset_n), .bus(bus1));
    data_memory_responder #(.ADDR_WIDTH(18), .DEPTH_WORDS(DEPTH), .LATENCY(0)) u_lat0 (
        .clock(clock), .reset_n(reset_n), .bus(bus2));

    function automatic int lat_of(input int s);
        return (s == 0) ? 2 : (s == 1) ? 4 : 0;
    endfunction

    // Reference behaviour of one request against the selected responder's storage.
    function automatic exp_t model_access(input logic rd, input logic wr, input logic byt,
                                          input logic [17:0] addr, input logic [31:0] wdata);
        exp_t        e;
        int          key;
        logic [31:0] w;
        logic [7:0]  b;
        e.lat   = lat_of(sel) + 1;
        e.rdata = 32'h0;
        e.error = (rd == wr) || (!byt && addr[1:0] != 2'b00) || (int'(addr) >= DEPTH * 4);
        if (!e.error) begin
            key = sel * DEPTH + int'(addr >> 2);
            w   = model.exists(key) ? model[key] : 32'h0;
            if (wr) begin
                if (byt) w[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
                else     w = wdata;
                model[key] = w;
            end else if (byt) begin
                b       = w[{addr[1:0], 3'b000} +: 8];
                e.rdata = {{24{b[7]}}, b};
            end else begin
                e.rdata = w;
            end
        end
        return e;
    endfunction

    task automatic drive(input logic rd, input logic wr, input logic byt,
                         input logic [17:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1; req_read = rd; req_write = wr; req_byte = byt;
        req_addr = addr; req_wdata = wdata;
    endtask

    // Called at a negedge; returns #1 after the accept edge.
    task automatic send(input string name, input logic rd, input logic wr, input logic byt,
                        input logic [17:0] addr, input logic [31:0] wdata);
        int n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (req_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_ready: req_ready=%b, required 1", name, req_ready);
        end
        drive(rd, wr, byt, addr, wdata);
        sb.push_back(model_access(rd, wr, byt, addr, wdata));
        @(posedge clock);
        #1 req_valid = 1'b0;
    endtask

    task automatic recv(input string name);
        exp_t e;
        int   n = 0;
        resp_ready = 1'b1;
        do begin
            @(negedge clock);
            n++;
        end while (resp_valid !== 1'b1 && n < 40);
        vectors++;
        if (resp_valid !== 1'b1 || sb.size() == 0) begin
            miscompares++;
            $display("FAIL %s_resp: resp_valid=%b after %0d cycles, queued=%0d, required 1", name,
                     resp_valid, n, sb.size());
            if (sb.size() != 0) void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            vectors += 3;
            if (n != e.lat) begin
                miscompares++;
                $display("FAIL %s_latency: resp_valid after %0d cycles, required %0d", name, n, e.lat);
            end
            if (resp_rdata !== e.rdata) begin
                miscompares++;
                $display("FAIL %s_rdata: got %h, required %h", name, resp_rdata, e.rdata);
            end
            if (resp_error !== e.error) begin
                miscompares++;
                $display("FAIL %s_error: got %b, required %b", name, resp_error, e.error);
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic xact(input string name, input logic rd, input logic wr, input logic byt,
                        input logic [17:0] addr, input logic [31:0] wdata);
        send(name, rd, wr, byt, addr, wdata);
        recv(name);
    endtask

    task automatic check_idle(input string name, input logic rv, input logic rr,
                              input logic [31:0] rd, input logic er);
        vectors++;
        if (rr !== 1'b1 || rv !== 1'b0 || rd !== 32'h0 || er !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: ready=%b valid=%b rdata=%h error=%b, required 1 0 00000000 0",
                     name, rr, rv, rd, er);
        end
    endtask

    task automatic test_reset();
        sel = 0;
        reset_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 18'h10, 32'h0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_idle("reset_lat2", bus0.resp_valid, bus0.req_ready, bus0.resp_rdata, bus0.resp_error);
        check_idle("reset_lat4", bus1.resp_valid, bus1.req_ready, bus1.resp_rdata, bus1.resp_error);
        check_idle("reset_lat0", bus2.resp_valid, bus2.req_ready, bus2.resp_rdata, bus2.resp_error);
        reset_n = 1'b1;
        req_valid = 1'b0;
        repeat (4) @(negedge clock);
        check_idle("reset_with_valid", resp_valid, req_ready, resp_rdata, resp_error);
    endtask

    task automatic test_word();
        sel = 0;
        xact("st_word", 1'b0, 1'b1, 1'b0, 18'h10, 32'hDEADBEEF);
        xact("ld_word", 1'b1, 1'b0, 1'b0, 18'h10, 32'h0);
        xact("st_last", 1'b0, 1'b1, 1'b0, 18'hFFC, 32'h0BADF00D);
        xact("ld_last", 1'b1, 1'b0, 1'b0, 18'hFFC, 32'h0);
    endtask

    task automatic test_byte();
        sel = 0;
        xact("st_zero", 1'b0, 1'b1, 1'b0, 18'h20, 32'h00000000);
        xact("st_byte", 1'b0, 1'b1, 1'b1, 18'h22, 32'hAAAAAA80);
        xact("ld_w20",  1'b1, 1'b0, 1'b0, 18'h20, 32'h0);
        xact("ld_b22",  1'b1, 1'b0, 1'b1, 18'h22, 32'h0);
        xact("ld_b21",  1'b1, 1'b0, 1'b1, 18'h21, 32'h0);
        xact("st_b13",  1'b0, 1'b1, 1'b1, 18'h13, 32'h0000007F);
        xact("ld_b13",  1'b1, 1'b0, 1'b1, 18'h13, 32'h0);
        xact("ld_w10",  1'b1, 1'b0, 1'b0, 18'h10, 32'h0);
    endtask

    task automatic test_errors();
        sel = 0;
        xact("err_unaligned", 1'b1, 1'b0, 1'b0, 18'h13, 32'h0);
        xact("err_rdwr",      1'b1, 1'b1, 1'b0, 18'h20, 32'hFFFFFFFF);
        xact("err_none",      1'b0, 1'b0, 1'b1, 18'h21, 32'hFFFFFFFF);
        xact("err_range",     1'b1, 1'b0, 1'b0, 18'h1000, 32'h0);
        xact("err_st_range",  1'b0, 1'b1, 1'b1, 18'h1001, 32'h000000FF);
        xact("err_st_unal",   1'b0, 1'b1, 1'b0, 18'h12, 32'h11111111);
        xact("after_err_10",  1'b1, 1'b0, 1'b0, 18'h10, 32'h0);
        xact("after_err_20",  1'b1, 1'b0, 1'b0, 18'h20, 32'h0);
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   n = 0;
        sel = 0;
        resp_ready = 1'b0;
        send("bp", 1'b1, 1'b0, 1'b0, 18'h10, 32'h0);
        while (resp_valid !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        e = sb.pop_front();
        drive(1'b1, 1'b0, 1'b0, 18'h20, 32'h0);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (resp_valid !== 1'b1 || resp_rdata !== e.rdata || resp_error !== e.error
                || req_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold%0d: valid=%b rdata=%h error=%b ready=%b, required 1 %h %b 0",
                         i, resp_valid, resp_rdata, resp_error, req_ready, e.rdata, e.error);
            end
            @(negedge clock);
        end
        resp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_idle("bp_after_handshake", resp_valid, req_ready, resp_rdata, resp_error);
        send("bp_next", 1'b1, 1'b0, 1'b0, 18'h20, 32'h0);
        recv("bp_next");
    endtask

    task automatic test_reset_mid_op();
        int n = 0;
        sel = 1;
        xact("rst_old", 1'b0, 1'b1, 1'b0, 18'h40, 32'hCAFEF00D);
        drive(1'b0, 1'b1, 1'b0, 18'h40, 32'h12345678);
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check_idle("rst_mid_wait", resp_valid, req_ready, resp_rdata, resp_error);
        reset_n = 1'b1;
        repeat (6) @(negedge clock);
        check_idle("rst_dropped", resp_valid, req_ready, resp_rdata, resp_error);
        xact("rst_ld40", 1'b1, 1'b0, 1'b0, 18'h40, 32'h0);

        resp_ready = 1'b0;
        send("rst_resp", 1'b0, 1'b1, 1'b0, 18'h44, 32'h5A5A5A5A);
        while (resp_valid !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        void'(sb.pop_front());
        reset_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        check_idle("rst_mid_resp", resp_valid, req_ready, resp_rdata, resp_error);
        xact("rst_ld44", 1'b1, 1'b0, 1'b0, 18'h44, 32'h0);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   accepts[$];
        int   n_resp = 0;
        sel = 2;
        xact("l0_store", 1'b0, 1'b1, 1'b0, 18'h80, 32'h11223344);
        xact("l0_load",  1'b1, 1'b0, 1'b1, 18'h83, 32'h0);
        resp_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 18'h80, 32'h0);
        for (int i = 0; i < 12; i++) begin
            if (resp_valid === 1'b1) begin
                n_resp++;
                vectors++;
                e = (sb.size() != 0) ? sb.pop_front() : '{32'hX, 1'bX, 0};
                if (resp_rdata !== e.rdata || resp_error !== e.error) begin
                    miscompares++;
                    $display("FAIL b2b_resp%0d: rdata=%h error=%b, required %h %b",
                             i, resp_rdata, resp_error, e.rdata, e.error);
                end
            end
            if (req_ready === 1'b1 && req_valid) begin
                sb.push_back(model_access(1'b1, 1'b0, 1'b0, 18'h80, 32'h0));
                accepts.push_back(i);
            end
            if (i == 11) req_valid = 1'b0;
            @(negedge clock);
        end
        vectors++;
        if (accepts.size() != 6 || n_resp != 6 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_count: accepts=%0d responses=%0d left=%0d, required 6 6 0",
                     accepts.size(), n_resp, sb.size());
        end
        for (int k = 1; k < accepts.size(); k++) begin
            vectors++;
            if (accepts[k] - accepts[k-1] != 2) begin
                miscompares++;
                $display("FAIL b2b_gap%0d: gap=%0d cycles, required 2", k, accepts[k] - accepts[k-1]);
            end
        end
        sb.delete();
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_word();
        test_byte();
        test_errors();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
